// File: rtl/ux607_tlb_ram_ctrl_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : ux607_tlb_ram_ctrl_pkg                                      |
// | Brief   : Shared widths and sequencer state encoding for the TLB RAM. |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package ux607_tlb_ram_ctrl_pkg;

    localparam int UX607_TLB_INDEX_WIDTH = 6;
    localparam int UX607_TLB_DATA_WIDTH  = 64;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_FLUSH = 2'd2
    } tlb_state_e;

endpackage
`default_nettype wire

// File: rtl/ux607_tlb_sweep_cnt.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : ux607_tlb_sweep_cnt                                         |
// | Brief   : Sweep index counter with last-entry flag for INIT/FLUSH.    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module ux607_tlb_sweep_cnt #(
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [AW-1:0] idx,
    output logic          last
);

    // One spare MSB so the DP-1 compare and the wrap can never alias.
    localparam logic [AW:0] C_LAST = {1'b0, {AW{1'b1}}};

    logic [AW:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign idx  = r_cnt[AW-1:0];
    assign last = (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/ux607_tlb_ram_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : ux607_tlb_ram_ctrl                                          |
// | Brief   : Arbiter/sequencer sharing one single-port TLB RAM between   |
// |           lookups, refills and the invalidate-all sweep.              |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module ux607_tlb_ram_ctrl
    import ux607_tlb_ram_ctrl_pkg::*;
#(
    parameter int AW = UX607_TLB_INDEX_WIDTH,
    parameter int DW = UX607_TLB_DATA_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          lkp_valid,
    output logic          lkp_ready,
    input  logic [AW-1:0] lkp_idx,
    output logic          lkp_rsp_vld,
    output logic [DW-1:0] lkp_rsp_data,
    input  logic          rfl_valid,
    output logic          rfl_ready,
    input  logic [AW-1:0] rfl_idx,
    input  logic [DW-1:0] rfl_data,
    input  logic          flush_req,
    output logic          flush_busy,
    output logic          flush_done,
    output logic          ram_cs,
    output logic          ram_wem,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    tlb_state_e    r_state;
    logic          r_flush_pend;
    logic          r_flush_done;
    logic          r_lkp_rsp_vld;

    logic          w_sweep;
    logic          w_idle;
    logic          w_flush_go;
    logic          w_rfl_gnt;
    logic          w_lkp_gnt;
    logic          w_last;
    logic [AW-1:0] w_sweep_idx;

    // Grants are decoded from state and request valids only, never from ram_dout.
    assign w_sweep    = !rst && ((r_state == ST_INIT) || (r_state == ST_FLUSH));
    assign w_idle     = !rst && (r_state == ST_IDLE);
    assign w_flush_go = w_idle && (flush_req || r_flush_pend);
    assign w_rfl_gnt  = w_idle && !w_flush_go && rfl_valid;
    assign w_lkp_gnt  = w_idle && !w_flush_go && !rfl_valid && lkp_valid;

    ux607_tlb_sweep_cnt #(
        .AW (AW)
    ) u_sweep_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (!w_sweep || w_last),
        .en   (w_sweep),
        .idx  (w_sweep_idx),
        .last (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_INIT;
            r_flush_pend  <= 1'b0;
            r_flush_done  <= 1'b0;
            r_lkp_rsp_vld <= 1'b0;
        end else begin
            r_flush_done  <= 1'b0;
            r_lkp_rsp_vld <= w_lkp_gnt;
            case (r_state)
                ST_INIT: begin
                    if (w_last) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (w_flush_go) begin
                        r_state      <= ST_FLUSH;
                        r_flush_pend <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    // A request arriving mid-sweep buys one more complete sweep.
                    if (flush_req) begin
                        r_flush_pend <= 1'b1;
                    end
                    if (w_last) begin
                        r_state      <= ST_IDLE;
                        r_flush_done <= 1'b1;
                    end
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    assign lkp_ready    = w_lkp_gnt;
    assign rfl_ready    = w_rfl_gnt;
    assign flush_busy   = w_sweep;
    assign flush_done   = r_flush_done;
    assign lkp_rsp_vld  = r_lkp_rsp_vld;
    assign lkp_rsp_data = r_lkp_rsp_vld ? ram_dout : '0;

    assign ram_cs   = w_sweep || w_rfl_gnt || w_lkp_gnt;
    assign ram_wem  = w_sweep || w_rfl_gnt;
    assign ram_addr = w_sweep   ? w_sweep_idx :
                      w_rfl_gnt ? rfl_idx     :
                      w_lkp_gnt ? lkp_idx     : '0;
    assign ram_din  = w_rfl_gnt ? rfl_data : '0;

endmodule
`default_nettype wire

// File: tb/tb_ux607_tlb_ram_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : tb_ux607_tlb_ram_ctrl                                       |
// | Brief   : Self-checking bench for the TLB RAM sequencer (AW=3).       |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_ux607_tlb_ram_ctrl;

    localparam int AW = 3;
    localparam int DW = 64;
    localparam int DP = 1 << AW;

    logic          clk;
    logic          rst;
    logic          lkp_valid;
    logic          lkp_ready;
    logic [AW-1:0] lkp_idx;
    logic          lkp_rsp_vld;
    logic [DW-1:0] lkp_rsp_data;
    logic          rfl_valid;
    logic          rfl_ready;
    logic [AW-1:0] rfl_idx;
    logic [DW-1:0] rfl_data;
    logic          flush_req;
    logic          flush_busy;
    logic          flush_done;
    logic          ram_cs;
    logic          ram_wem;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] ram_mem [DP];
    logic [DW-1:0] model   [DP];
    logic [DW-1:0] sb_q    [$];

    ux607_tlb_ram_ctrl #(
        .AW (AW),
        .DW (DW)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .lkp_valid    (lkp_valid),
        .lkp_ready    (lkp_ready),
        .lkp_idx      (lkp_idx),
        .lkp_rsp_vld  (lkp_rsp_vld),
        .lkp_rsp_data (lkp_rsp_data),
        .rfl_valid    (rfl_valid),
        .rfl_ready    (rfl_ready),
        .rfl_idx      (rfl_idx),
        .rfl_data     (rfl_data),
        .flush_req    (flush_req),
        .flush_busy   (flush_busy),
        .flush_done   (flush_done),
        .ram_cs       (ram_cs),
        .ram_wem      (ram_wem),
        .ram_addr     (ram_addr),
        .ram_din      (ram_din),
        .ram_dout     (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM with garbage power-up contents, so the init sweep matters.
    initial begin
        for (int i = 0; i < DP; i++) ram_mem[i] = {$urandom, $urandom};
        ram_dout = {$urandom, $urandom};
    end

    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_wem) ram_mem[ram_addr] <= ram_din;
            else         ram_dout <= ram_mem[ram_addr];
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < DP; i++) model[i] = '0;
    endtask

    task automatic expect_sweep(input int k);
        check_eq("sweep_cs",   ram_cs,     1);
        check_eq("sweep_wem",  ram_wem,    1);
        check_eq("sweep_addr", ram_addr,   64'(k));
        check_eq("sweep_din",  ram_din,    0);
        check_eq("sweep_busy", flush_busy, 1);
        check_eq("sweep_lkp_ready", lkp_ready, 0);
        check_eq("sweep_rfl_ready", rfl_ready, 0);
    endtask

    // Scoreboard: expected read data is queued when a lookup is accepted.
    always @(negedge clk) begin
        if (!rst) begin
            if (lkp_rsp_vld) begin
                check_eq("sb_nonempty", 64'(sb_q.size() != 0), 1);
                if (sb_q.size() != 0) check_eq("lkp_rsp_data", lkp_rsp_data, sb_q.pop_front());
            end
            if (lkp_valid && lkp_ready) sb_q.push_back(model[lkp_idx]);
            if (rfl_valid && rfl_ready) model[rfl_idx] = rfl_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; lkp_valid = 1'b0; lkp_idx = '0; rfl_valid = 1'b0;
        rfl_idx = '0; rfl_data = '0; flush_req = 1'b0;
        clear_model();

        // Reset state
        tick(); settle();
        check_eq("rst_ram_cs",      ram_cs,      0);
        check_eq("rst_flush_busy",  flush_busy,  0);
        check_eq("rst_lkp_ready",   lkp_ready,   0);
        check_eq("rst_rfl_ready",   rfl_ready,   0);
        check_eq("rst_lkp_rsp_vld", lkp_rsp_vld, 0);
        check_eq("rst_flush_done",  flush_done,  0);

        // Post-reset zero fill; a waiting lookup is held off until IDLE
        tick(); rst = 1'b0; lkp_valid = 1'b1; lkp_idx = 3'd3;
        for (int i = 0; i < DP; i++) begin
            settle(); expect_sweep(i);
            check_eq("init_flush_done", flush_done, 0);
            tick();
        end
        settle();
        check_eq("idle_lkp_ready",  lkp_ready,  1);
        check_eq("idle_lkp_wem",    ram_wem,    0);
        check_eq("idle_lkp_addr",   ram_addr,   3);
        check_eq("idle_flush_busy", flush_busy, 0);
        check_eq("init_no_done",    flush_done, 0);
        tick(); lkp_valid = 1'b0; settle();
        check_eq("rsp_vld_after_init", lkp_rsp_vld, 1);

        // Refill then lookup of the same index
        rfl_valid = 1'b1; rfl_idx = 3'd5; rfl_data = 64'hABCD; settle();
        check_eq("rfl_ready", rfl_ready, 1);
        check_eq("rfl_wem",   ram_wem,   1);
        check_eq("rfl_addr",  ram_addr,  5);
        check_eq("rfl_din",   ram_din,   64'hABCD);
        tick(); rfl_valid = 1'b0; lkp_valid = 1'b1; lkp_idx = 3'd5; settle();
        check_eq("lkp5_ready", lkp_ready, 1);
        tick(); lkp_valid = 1'b0; settle();
        check_eq("lkp5_rsp_vld",  lkp_rsp_vld,  1);
        check_eq("lkp5_rsp_data", lkp_rsp_data, 64'hABCD);
        tick(); settle();
        check_eq("lkp5_rsp_vld_pulse", lkp_rsp_vld, 0);

        // Simultaneous refill and lookup: refill first, lookup next cycle
        rfl_valid = 1'b1; rfl_idx = 3'd2; rfl_data = 64'h1234;
        lkp_valid = 1'b1; lkp_idx = 3'd2; settle();
        check_eq("both_rfl_ready", rfl_ready, 1);
        check_eq("both_lkp_ready", lkp_ready, 0);
        tick(); rfl_valid = 1'b0; settle();
        check_eq("stalled_lkp_ready", lkp_ready, 1);
        check_eq("stalled_lkp_wem",   ram_wem,   0);
        tick(); lkp_valid = 1'b0; settle();
        check_eq("stalled_rsp_vld", lkp_rsp_vld, 1);

        // Flush from IDLE with a lookup waiting
        tick(); flush_req = 1'b1; lkp_valid = 1'b1; lkp_idx = 3'd5; settle();
        check_eq("flush_go_cs",        ram_cs,     0);
        check_eq("flush_go_lkp_ready", lkp_ready,  0);
        check_eq("flush_go_busy",      flush_busy, 0);
        tick(); flush_req = 1'b0;
        for (int i = 0; i < DP; i++) begin
            settle(); expect_sweep(i); tick();
        end
        clear_model(); settle();
        check_eq("flush_done",          flush_done, 1);
        check_eq("flush_end_lkp_ready", lkp_ready,  1);
        tick(); lkp_valid = 1'b0; settle();
        check_eq("flush_done_pulse",  flush_done,  0);
        check_eq("flushed_rsp_vld",   lkp_rsp_vld, 1);

        // Flush request during a sweep queues exactly one more sweep
        tick(); flush_req = 1'b1; settle();
        check_eq("flush2_go_cs", ram_cs, 0);
        tick();
        for (int i = 0; i < DP; i++) begin
            flush_req = (i == 3);
            settle(); expect_sweep(i); tick();
        end
        flush_req = 1'b0; settle();
        check_eq("sweep1_done",    flush_done, 1);
        check_eq("sweep1_gap_cs",  ram_cs,     0);
        check_eq("sweep1_gap_bsy", flush_busy, 0);
        tick();
        for (int i = 0; i < DP; i++) begin
            settle(); expect_sweep(i);
            if (i == 0) check_eq("sweep2_no_early_done", flush_done, 0);
            tick();
        end
        settle();
        check_eq("sweep2_done", flush_done, 1);
        check_eq("sweep2_busy", flush_busy, 0);
        tick(); settle();
        check_eq("no_third_sweep",  flush_busy, 0);
        check_eq("sweep2_done_end", flush_done, 0);

        // Reset in the middle of a flush restarts the init sweep at 0
        rfl_valid = 1'b1; rfl_idx = 3'd6; rfl_data = 64'h5A5A; settle();
        check_eq("rfl6_ready", rfl_ready, 1);
        tick(); rfl_valid = 1'b0; flush_req = 1'b1; settle();
        tick(); flush_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle(); expect_sweep(i);
            if (i == 4) rst = 1'b1;
            tick();
        end
        settle();
        check_eq("midrst_cs",      ram_cs,      0);
        check_eq("midrst_busy",    flush_busy,  0);
        check_eq("midrst_rsp_vld", lkp_rsp_vld, 0);
        check_eq("midrst_done",    flush_done,  0);
        rst = 1'b0;
        for (int i = 0; i < DP; i++) begin
            settle(); expect_sweep(i); tick();
        end
        clear_model(); lkp_valid = 1'b1; lkp_idx = 3'd6; settle();
        check_eq("reinit_lkp_ready", lkp_ready,  1);
        check_eq("reinit_no_done",   flush_done, 0);
        tick(); lkp_valid = 1'b0; settle();
        check_eq("reinit_rsp_vld", lkp_rsp_vld, 1);
        tick(); settle();
        check_eq("sb_drained", 64'(sb_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
